// File: rtl/muldiv_pkg.sv
// rtl/muldiv_pkg.sv - shared op codes, FSM states and helpers for the mul/div sequencer
package muldiv_pkg;

    // ex_op encodings presented by the EX stage
    localparam logic [2:0] MD_NONE = 3'd0;
    localparam logic [2:0] MULT    = 3'd1;
    localparam logic [2:0] MULTU   = 3'd2;
    localparam logic [2:0] DIV     = 3'd3;
    localparam logic [2:0] DIVU    = 3'd4;
    localparam logic [2:0] MTHI    = 3'd5;
    localparam logic [2:0] MTLO    = 3'd6;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        FINISH = 2'd2
    } mdState_e;

    // Ops that occupy the iterative datapath (MTHI/MTLO complete in one edge)
    function automatic logic isMulDiv(input logic [2:0] op);
        return (op == MULT) || (op == MULTU) || (op == DIV) || (op == DIVU);
    endfunction

endpackage

// File: rtl/muldiv_ctrl_md_iter_step.sv
// rtl/muldiv_ctrl_md_iter_step.sv - one combinational radix-2 multiply or divide iteration
// Ports:
//   acc      in  2W  working register {upper, lower}
//   operand  in  W   multiplicand (mul) or divisor (div)
//   is_div   in  1   0: shift-add multiply step, 1: restoring divide step
//   acc_next out 2W  working register after this iteration
module md_iter_step #(
    parameter int W = 32
) (
    input  logic [2*W-1:0] acc,
    input  logic [W-1:0]   operand,
    input  logic           is_div,
    output logic [2*W-1:0] acc_next
);

    logic [W:0] addSum;
    logic [W:0] shiftRem;
    logic [W:0] subDiff;

    always_comb begin
        // Multiply: multiplier sits in the lower half and is consumed LSB first;
        // the carry out of the add becomes the new MSB after the right shift.
        addSum   = {1'b0, acc[2*W-1:W]} + (acc[0] ? {1'b0, operand} : {(W+1){1'b0}});
        // Divide: shift the next dividend bit into the partial remainder.
        shiftRem = {acc[2*W-1:W], acc[W-1]};
        subDiff  = shiftRem - {1'b0, operand};
        if (is_div) begin
            // Bit W of the difference is the borrow: remainder smaller than divisor.
            if (subDiff[W]) begin
                acc_next = {shiftRem[W-1:0], acc[W-2:0], 1'b0};
            end else begin
                acc_next = {subDiff[W-1:0], acc[W-2:0], 1'b1};
            end
        end else begin
            acc_next = {addSum, acc[W-1:1]};
        end
    end

endmodule

// File: rtl/muldiv_ctrl.sv
// rtl/muldiv_ctrl.sv - multi-cycle multiply/divide sequencer owning HI/LO
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   ex_valid, ex_op      EX instruction valid and its mul/div/MT op code
//   ex_rd_hilo, ex_rd_sel EX instruction is MFHI/MFLO, and which register it reads
//   src_a, src_b         forwarded rs / rt operands
//   flush                abort any in-flight operation
//   busy, stall          iteration in progress / freeze IF-ID-EX
//   hilo_rdata           HI or LO as selected by ex_rd_sel
//   hi, lo               architectural HI/LO
module muldiv_ctrl
    import muldiv_pkg::*;
#(
    parameter int W     = 32,
    parameter int CNT_W = 6
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         ex_valid,
    input  logic [2:0]   ex_op,
    input  logic         ex_rd_hilo,
    input  logic         ex_rd_sel,
    input  logic [W-1:0] src_a,
    input  logic [W-1:0] src_b,
    input  logic         flush,
    output logic         busy,
    output logic         stall,
    output logic [W-1:0] hilo_rdata,
    output logic [W-1:0] hi,
    output logic [W-1:0] lo
);

    mdState_e       state, stateNext;
    logic [CNT_W-1:0] cnt;
    logic [2*W-1:0] acc, accNext;
    logic [W-1:0]   operand;
    logic           isDiv, negLo, negHi, divZero;

    logic           accept, opSigned, signA, signB;
    logic [W-1:0]   absA, absB;
    logic [2*W-1:0] prodFixed;
    logic [W-1:0]   hiRes, loRes;

    assign accept   = (state == IDLE) && ex_valid && !flush && isMulDiv(ex_op);
    assign opSigned = (ex_op == MULT) || (ex_op == DIV);
    assign signA    = opSigned && src_a[W-1];
    assign signB    = opSigned && src_b[W-1];
    assign absA     = signA ? -src_a : src_a;
    assign absB     = signB ? -src_b : src_b;

    md_iter_step #(.W(W)) u_step (
        .acc      (acc),
        .operand  (operand),
        .is_div   (isDiv),
        .acc_next (accNext)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    // Next-state logic
    always_comb begin
        stateNext = state;
        case (state)
            IDLE:    if (accept) stateNext = RUN;
            RUN:     if (flush) stateNext = IDLE;
                     else if (cnt == CNT_W'(1)) stateNext = FINISH;
            FINISH:  stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    // Outputs
    always_comb begin
        busy = (state != IDLE);
    end

    assign stall      = busy && ex_valid && (ex_rd_hilo || (ex_op != MD_NONE));
    assign hilo_rdata = ex_rd_sel ? hi : lo;

    // Work registers: operands in magnitude form, sign flags remembered for fix-up.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt     <= '0;
            acc     <= '0;
            operand <= '0;
            isDiv   <= 1'b0;
            negLo   <= 1'b0;
            negHi   <= 1'b0;
            divZero <= 1'b0;
        end else if (accept) begin
            cnt     <= CNT_W'(W);
            isDiv   <= (ex_op == DIV) || (ex_op == DIVU);
            negLo   <= signA ^ signB;
            negHi   <= signA;
            divZero <= ((ex_op == DIV) || (ex_op == DIVU)) && (src_b == '0);
            if ((ex_op == DIV) || (ex_op == DIVU)) begin
                acc     <= {{W{1'b0}}, absA};
                operand <= absB;
            end else begin
                acc     <= {{W{1'b0}}, absB};
                operand <= absA;
            end
        end else if ((state == RUN) && !flush) begin
            acc <= accNext;
            cnt <= cnt - CNT_W'(1);
        end
    end

    // Sign fix-up. With a zero divisor the restoring loop leaves |a| as the
    // remainder, so re-applying sign(a) reproduces the original src_a for HI.
    always_comb begin
        prodFixed = negLo ? -acc : acc;
        if (isDiv) begin
            hiRes = negHi ? -acc[2*W-1:W] : acc[2*W-1:W];
            loRes = divZero ? {W{1'b1}} : (negLo ? -acc[W-1:0] : acc[W-1:0]);
        end else begin
            hiRes = prodFixed[2*W-1:W];
            loRes = prodFixed[W-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hi <= '0;
            lo <= '0;
        end else if ((state == FINISH) && !flush) begin
            hi <= hiRes;
            lo <= loRes;
        end else if ((state == IDLE) && ex_valid && !flush) begin
            if (ex_op == MTHI) hi <= src_a;
            if (ex_op == MTLO) lo <= src_a;
        end
    end

endmodule

// File: tb/tb_muldiv_ctrl.sv
// tb/tb_muldiv_ctrl.sv - self-checking bench for muldiv_ctrl
module tb_muldiv_ctrl;
    import muldiv_pkg::*;

    localparam int W = 32;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ex_valid = 1'b0;
    logic [2:0]  ex_op = MD_NONE;
    logic        ex_rd_hilo = 1'b0;
    logic        ex_rd_sel = 1'b0;
    logic [31:0] src_a = '0;
    logic [31:0] src_b = '0;
    logic        flush = 1'b0;
    logic        busy, stall;
    logic [31:0] hilo_rdata, hi, lo;

    int errors = 0;
    int checks = 0;

    muldiv_ctrl #(.W(W), .CNT_W(6)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ex_valid   (ex_valid),
        .ex_op      (ex_op),
        .ex_rd_hilo (ex_rd_hilo),
        .ex_rd_sel  (ex_rd_sel),
        .src_a      (src_a),
        .src_b      (src_b),
        .flush      (flush),
        .busy       (busy),
        .stall      (stall),
        .hilo_rdata (hilo_rdata),
        .hi         (hi),
        .lo         (lo)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
        end
    endtask

    // Architectural result {hi, lo} from plain arithmetic
    function automatic logic [63:0] mdModel(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        longint p;
        int     sa, sb, q, r;
        case (op)
            MULTU: return {32'h0, a} * {32'h0, b};
            MULT: begin
                p = longint'($signed(a)) * longint'($signed(b));
                return p;
            end
            DIVU: begin
                if (b == 0) return {a, 32'hFFFF_FFFF};
                return {a % b, a / b};
            end
            DIV: begin
                if (b == 0) return {a, 32'hFFFF_FFFF};
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
                sa = a;
                sb = b;
                q = sa / sb;
                r = sa % sb;
                return {r, q};
            end
            default: return 64'h0;
        endcase
    endfunction

    // Cycle-level model: remaining busy cycles plus pending result
    int          mBusyLeft = 0;
    logic [31:0] mHi = '0, mLo = '0, pHi = '0, pLo = '0;
    logic        mStalled = 1'b0;
    logic [63:0] mRes;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mBusyLeft <= 0;
            mHi <= '0;
            mLo <= '0;
            mStalled <= 1'b0;
        end else begin
            mStalled <= (mBusyLeft > 0) && ex_valid && (ex_rd_hilo || ex_op != MD_NONE);
            if (mBusyLeft > 0) begin
                if (flush) begin
                    mBusyLeft <= 0;
                end else begin
                    mBusyLeft <= mBusyLeft - 1;
                    if (mBusyLeft == 1) begin
                        mHi <= pHi;
                        mLo <= pLo;
                    end
                end
            end else if (ex_valid && !flush) begin
                if (ex_op inside {MULT, MULTU, DIV, DIVU}) begin
                    mRes = mdModel(ex_op, src_a, src_b);
                    pHi <= mRes[63:32];
                    pLo <= mRes[31:0];
                    mBusyLeft <= W + 1;
                end else if (ex_op == MTHI) begin
                    mHi <= src_a;
                end else if (ex_op == MTLO) begin
                    mLo <= src_a;
                end
            end
        end
    end

    // Every-cycle compare of DUT outputs against the model
    always @(negedge clk) begin
        logic expBusy;
        expBusy = (mBusyLeft > 0);
        check("cyc_busy", 32'(busy), 32'(expBusy));
        check("cyc_stall", 32'(stall), 32'(expBusy && ex_valid && (ex_rd_hilo || ex_op != MD_NONE)));
        check("cyc_hi", hi, mHi);
        check("cyc_lo", lo, mLo);
        check("cyc_rdata", hilo_rdata, ex_rd_sel ? mHi : mLo);
    end

    task automatic setIdle();
        ex_valid = 1'b0;
        ex_op = MD_NONE;
        ex_rd_hilo = 1'b0;
        ex_rd_sel = 1'b0;
    endtask

    // Present an instruction and hold it until the model says it was not stalled
    task automatic present(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, output int tries);
        ex_valid = 1'b1;
        ex_op = op;
        ex_rd_hilo = 1'b0;
        src_a = a;
        src_b = b;
        tries = 0;
        do begin
            @(posedge clk);
            #2;
            tries++;
        end while (mStalled && tries < 200);
        if (mStalled) begin
            checks++;
            errors++;
            $display("FAIL present_timeout: op %0d still stalled after %0d cycles", op, tries);
        end
        setIdle();
    endtask

    task automatic waitIdle();
        int n = 0;
        while (mBusyLeft > 0 && n < 100) begin
            @(posedge clk);
            #2;
            n++;
        end
        if (mBusyLeft > 0) begin
            checks++;
            errors++;
            $display("FAIL wait_idle_timeout: model busy after %0d cycles", n);
        end
    endtask

    task automatic runOp(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        int t;
        present(op, a, b, t);
        waitIdle();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int t;
        logic [63:0] r;
        int sel;

        // Model pinned against hand-computed values
        r = mdModel(MULTU, 32'hFFFF_FFFF, 32'd2);
        check("pin_multu_hi", r[63:32], 32'h1);
        check("pin_multu_lo", r[31:0], 32'hFFFF_FFFE);
        r = mdModel(DIV, 32'hFFFF_FFF9, 32'd2);
        check("pin_div_lo", r[31:0], 32'hFFFF_FFFD);
        check("pin_div_hi", r[63:32], 32'hFFFF_FFFF);

        // Reset state
        repeat (3) @(posedge clk);
        #2;
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_stall", 32'(stall), 32'h0);
        check("rst_hi", hi, 32'h0);
        check("rst_lo", lo, 32'h0);
        rst_n = 1'b1;
        @(posedge clk);
        #2;

        // MULTU 0xFFFF_FFFF * 2, busy duration
        present(MULTU, 32'hFFFF_FFFF, 32'd2, t);
        n = 0;
        while (busy && n < 100) begin
            n++;
            @(posedge clk);
            #2;
        end
        check("multu_busy_cycles", n, 33);
        check("multu_hi", hi, 32'h1);
        check("multu_lo", lo, 32'hFFFF_FFFE);

        runOp(MULT, 32'hFFFF_FFFD, 32'd5);
        check("mult_hi", hi, 32'hFFFF_FFFF);
        check("mult_lo", lo, 32'hFFFF_FFF1);
        runOp(DIV, 32'hFFFF_FFF9, 32'd2);
        check("div_lo", lo, 32'hFFFF_FFFD);
        check("div_hi", hi, 32'hFFFF_FFFF);
        runOp(DIVU, 32'd10, 32'd0);
        check("divu0_lo", lo, 32'hFFFF_FFFF);
        check("divu0_hi", hi, 32'd10);
        runOp(DIV, 32'hFFFF_FFF9, 32'd0);
        check("div0_lo", lo, 32'hFFFF_FFFF);
        check("div0_hi", hi, 32'hFFFF_FFF9);
        runOp(DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        check("divovf_lo", lo, 32'h8000_0000);
        check("divovf_hi", hi, 32'h0);

        // MFLO one cycle after MULTU 6*7
        present(MULTU, 32'd6, 32'd7, t);
        ex_valid = 1'b1;
        ex_rd_hilo = 1'b1;
        ex_rd_sel = 1'b0;
        n = 0;
        @(negedge clk);
        while (stall && n < 100) begin
            n++;
            @(negedge clk);
        end
        check("mf_stall_cycles", n, 33);
        check("mf_rdata", hilo_rdata, 32'd42);
        @(posedge clk);
        #2;
        setIdle();

        // Back-to-back MULT: second accepted on first IDLE cycle
        present(MULT, 32'd3, 32'hFFFF_FFFC, t);
        present(MULT, 32'hFFFF_FFFE, 32'd7, t);
        check("b2b_tries", t, 34);
        waitIdle();
        check("b2b_hi", hi, 32'hFFFF_FFFF);
        check("b2b_lo", lo, 32'hFFFF_FFF2);

        // Flush mid-DIVU
        runOp(MTHI, 32'h55, 32'h0);
        runOp(MTLO, 32'h55, 32'h0);
        present(DIVU, 32'd100, 32'd3, t);
        repeat (9) begin
            @(posedge clk);
            #2;
        end
        flush = 1'b1;
        @(posedge clk);
        #2;
        flush = 1'b0;
        ex_valid = 1'b1;
        ex_rd_hilo = 1'b1;
        #1;
        check("flush_busy", 32'(busy), 32'h0);
        check("flush_stall", 32'(stall), 32'h0);
        check("flush_hi", hi, 32'h55);
        check("flush_lo", lo, 32'h55);
        setIdle();
        @(posedge clk);
        #2;

        // Asynchronous reset mid-RUN
        present(MULT, 32'd5, 32'd9, t);
        repeat (5) begin
            @(posedge clk);
            #2;
        end
        rst_n = 1'b0;
        #1;
        check("arst_busy", 32'(busy), 32'h0);
        check("arst_stall", 32'(stall), 32'h0);
        check("arst_hi", hi, 32'h0);
        check("arst_lo", lo, 32'h0);
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #2;
        present(MTHI, 32'h1234, 32'h0, t);
        check("mthi_hi", hi, 32'h1234);

        // Randomized per-cycle stimulus, checked by the compare process
        for (int i = 0; i < 6000; i++) begin
            @(posedge clk);
            #2;
            sel = $urandom_range(0, 15);
            case (sel)
                6, 7:    ex_op = MULT;
                8:       ex_op = MULTU;
                9:       ex_op = DIV;
                10:      ex_op = DIVU;
                11:      ex_op = MTHI;
                12:      ex_op = MTLO;
                default: ex_op = MD_NONE;
            endcase
            ex_valid = ($urandom_range(0, 3) != 0);
            ex_rd_hilo = ($urandom_range(0, 3) == 0);
            ex_rd_sel = 1'($urandom_range(0, 1));
            flush = ($urandom_range(0, 63) == 0);
            for (int k = 0; k < 2; k++) begin
                logic [31:0] v;
                case ($urandom_range(0, 5))
                    0:       v = 32'h0;
                    1:       v = 32'h1;
                    2:       v = 32'hFFFF_FFFF;
                    3:       v = 32'h8000_0000;
                    4:       v = $urandom_range(0, 20);
                    default: v = $urandom;
                endcase
                if (k == 0) src_a = v;
                else src_b = v;
            end
        end
        flush = 1'b0;
        setIdle();
        repeat (40) @(posedge clk);
        #2;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
